// File: rtl/timer_pkg.sv
// Shared types, BCD limits and helpers for the BCD countdown timer bank.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_RING  = 2'b11
  } ch_state_e;

  localparam logic [7:0]  BCD_MAX_MS = 8'h59;
  localparam logic [7:0]  BCD_MAX_H  = 8'h23;
  localparam int unsigned RCNT_W     = 8;

  // HH:MM:SS value, each field {tens,units} BCD
  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
  } hms_t;

  // Both nibbles of a BCD byte are decimal digits
  function automatic logic bcd_nib_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Legal time-of-day style load value
  function automatic logic bcd_valid(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s);
    return bcd_nib_ok(h) && bcd_nib_ok(m) && bcd_nib_ok(s) &&
           (h <= BCD_MAX_H) && (m <= BCD_MAX_MS) && (s <= BCD_MAX_MS);
  endfunction

  // BCD decrement of one byte; 00 wraps to the supplied value
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
    logic [7:0] r;
    r = wrap;
    if (v[3:0] != 4'd0)      r = {v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/bcd_timer_bank_if.sv
// Control/display bundle between the user-input/VGA side and the timer bank.
interface bcd_timer_bank_if #(
  parameter int unsigned N_CH = 4
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            tick_1hz;
  logic            ld_en;
  logic [CH_W-1:0] ld_ch;
  logic [7:0]      ld_h;
  logic [7:0]      ld_m;
  logic [7:0]      ld_s;
  logic            start;
  logic            stop;
  logic [CH_W-1:0] cmd_ch;
  logic [N_CH-1:0] apagar_alarma;
  logic [CH_W-1:0] sel_ch;
  logic [7:0]      h_VGA;
  logic [7:0]      mi_VGA;
  logic [7:0]      s_VGA;
  logic [N_CH-1:0] run;
  logic [N_CH-1:0] ring;
  logic            activring;
  logic            ld_err;

  modport master (
    output tick_1hz, ld_en, ld_ch, ld_h, ld_m, ld_s, start, stop, cmd_ch,
           apagar_alarma, sel_ch,
    input  h_VGA, mi_VGA, s_VGA, run, ring, activring, ld_err
  );

  modport slave (
    input  tick_1hz, ld_en, ld_ch, ld_h, ld_m, ld_s, start, stop, cmd_ch,
           apagar_alarma, sel_ch,
    output h_VGA, mi_VGA, s_VGA, run, ring, activring, ld_err
  );

endinterface

// File: rtl/bcd_timer_bank_hms_down.sv
// One HH:MM:SS countdown channel with run/pause control and a timed ring.
module bcd_hms_down
  import timer_pkg::*;
#(
  parameter int unsigned RING_SEC = 60
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_tick,
  input  logic      i_ld,
  input  hms_t      i_ld_val,
  input  logic      i_start,
  input  logic      i_stop,
  input  logic      i_ack,
  output hms_t      o_val,
  output ch_state_e o_state,
  output logic      o_run,
  output logic      o_ring
);

  ch_state_e         r_state, w_state_nx;
  hms_t              r_val, w_val_nx;
  logic [RCNT_W-1:0] r_rcnt, w_rcnt_nx;
  logic              w_nonzero;
  logic              w_last;

  // State, value and ring-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_val   <= '0;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_val   <= w_val_nx;
      r_rcnt  <= w_rcnt_nx;
    end
  end

  // Next state: load/start/stop control, BCD borrow chain, expiry and ring timeout
  always_comb begin
    w_state_nx = r_state;
    w_val_nx   = r_val;
    w_rcnt_nx  = r_rcnt;
    w_nonzero  = (r_val != '0);
    w_last     = (r_val == hms_t'(24'h000001));
    case (r_state)
      ST_IDLE, ST_PAUSE: begin
        if (i_ld) begin
          w_val_nx   = i_ld_val;
          w_state_nx = ST_IDLE;
        end else if (i_start && !i_stop && w_nonzero) begin
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_nx = ST_PAUSE;
        end else if (i_tick) begin
          if (w_last) begin
            w_val_nx   = '0;
            w_state_nx = ST_RING;
            w_rcnt_nx  = RCNT_W'(RING_SEC);
          end else begin
            w_val_nx.s = bcd_dec(r_val.s, BCD_MAX_MS);
            if (r_val.s == 8'h00) begin
              w_val_nx.m = bcd_dec(r_val.m, BCD_MAX_MS);
              if (r_val.m == 8'h00) w_val_nx.h = bcd_dec(r_val.h, 8'h00);
            end
          end
        end
      end
      ST_RING: begin
        if (i_ack) begin
          w_state_nx = ST_IDLE;
          w_rcnt_nx  = '0;
        end else if (i_tick) begin
          if (r_rcnt <= RCNT_W'(1)) begin
            w_state_nx = ST_IDLE;
            w_rcnt_nx  = '0;
          end else begin
            w_rcnt_nx = r_rcnt - RCNT_W'(1);
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign o_val   = r_val;
  assign o_state = r_state;
  assign o_run   = (r_state == ST_RUN);
  assign o_ring  = (r_state == ST_RING);

endmodule

// File: rtl/bcd_timer_bank.sv
// Bank of independent BCD countdown timers with display mux and combined ring flag.
module bcd_timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned RING_SEC = 60
) (
  input logic              CLK,
  input logic              btn_RESET_n,
  bcd_timer_bank_if.slave  bus
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  hms_t            w_val [N_CH];
  ch_state_e       w_state [N_CH];
  logic [N_CH-1:0] w_ld_hit;
  logic [N_CH-1:0] w_loadable;
  logic [N_CH-1:0] w_start;
  logic [N_CH-1:0] w_stop;
  logic [N_CH-1:0] w_run;
  logic [N_CH-1:0] w_ring;
  hms_t            w_ld_val;
  logic            w_ld_valid;
  logic            w_ld_ok;
  hms_t            w_disp;
  hms_t            r_disp;
  logic            r_ld_err;
  logic            r_activring;

  assign w_ld_val   = {bus.ld_h, bus.ld_m, bus.ld_s};
  assign w_ld_valid = bcd_valid(bus.ld_h, bus.ld_m, bus.ld_s);
  assign w_ld_ok    = w_ld_valid && (|(w_ld_hit & w_loadable));

  // Per-channel address decode and timer instances
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_ld_hit[gi]   = bus.ld_en && (bus.ld_ch == CH_W'(gi));
    assign w_start[gi]    = bus.start && (bus.cmd_ch == CH_W'(gi));
    assign w_stop[gi]     = bus.stop  && (bus.cmd_ch == CH_W'(gi));
    assign w_loadable[gi] = (w_state[gi] == ST_IDLE) || (w_state[gi] == ST_PAUSE);

    bcd_hms_down #(.RING_SEC(RING_SEC)) u_ch (
      .clk      (CLK),
      .rst_n    (btn_RESET_n),
      .i_tick   (bus.tick_1hz),
      .i_ld     (w_ld_hit[gi] && w_ld_valid && w_loadable[gi]),
      .i_ld_val (w_ld_val),
      .i_start  (w_start[gi]),
      .i_stop   (w_stop[gi]),
      .i_ack    (bus.apagar_alarma[gi]),
      .o_val    (w_val[gi]),
      .o_state  (w_state[gi]),
      .o_run    (w_run[gi]),
      .o_ring   (w_ring[gi])
    );
  end

  // Display source select; out-of-range channel shows zero
  always_comb begin
    w_disp = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.sel_ch == CH_W'(i)) w_disp = w_val[i];
    end
  end

  // Registered display, load-error pulse and combined ring flag
  always_ff @(posedge CLK or negedge btn_RESET_n) begin
    if (!btn_RESET_n) begin
      r_disp      <= '0;
      r_ld_err    <= 1'b0;
      r_activring <= 1'b0;
    end else begin
      r_disp      <= w_disp;
      r_ld_err    <= bus.ld_en && !w_ld_ok;
      r_activring <= |w_ring;
    end
  end

  assign bus.h_VGA     = r_disp.h;
  assign bus.mi_VGA    = r_disp.m;
  assign bus.s_VGA     = r_disp.s;
  assign bus.run       = w_run;
  assign bus.ring      = w_ring;
  assign bus.activring = r_activring;
  assign bus.ld_err    = r_ld_err;

endmodule

// File: tb/tb_bcd_timer_bank.sv
// Self-checking bench for bcd_timer_bank (4 channels, 3-tick ring).
module tb_bcd_timer_bank;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  bcd_timer_bank_if #(.N_CH(4)) bus ();

  bcd_timer_bank #(.N_CH(4), .RING_SEC(3)) dut (
    .CLK         (clk),
    .btn_RESET_n (rst_n),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          ld;
    logic [1:0]  ldc;
    logic [23:0] ldv;
    bit          st;
    bit          sp;
    logic [1:0]  cc;
    bit          tk;
    logic [3:0]  ak;
    logic [1:0]  sel;
    logic [3:0]  e_run;
    logic [3:0]  e_ring;
    bit          e_act;
    bit          e_err;
    bit          chk_d;
    logic [23:0] e_disp;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(bit ld, logic [1:0] ldc, logic [23:0] ldv, bit st, bit sp,
                              logic [1:0] cc, bit tk, logic [3:0] ak, logic [1:0] sel,
                              logic [3:0] er, logic [3:0] eg, bit ea, bit ee, bit cd,
                              logic [23:0] ed);
    vec_t v;
    v.ld = ld; v.ldc = ldc; v.ldv = ldv; v.st = st; v.sp = sp; v.cc = cc; v.tk = tk;
    v.ak = ak; v.sel = sel; v.e_run = er; v.e_ring = eg; v.e_act = ea; v.e_err = ee;
    v.chk_d = cd; v.e_disp = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    bus.ld_en         = v.ld;
    bus.ld_ch         = v.ldc;
    bus.ld_h          = v.ldv[23:16];
    bus.ld_m          = v.ldv[15:8];
    bus.ld_s          = v.ldv[7:0];
    bus.start         = v.st;
    bus.stop          = v.sp;
    bus.cmd_ch        = v.cc;
    bus.tick_1hz      = v.tk;
    bus.apagar_alarma = v.ak;
    bus.sel_ch        = v.sel;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_run"}, 32'(bus.run), 32'h0);
    chk({tag, "_ring"}, 32'(bus.ring), 32'h0);
    chk({tag, "_act"}, 32'(bus.activring), 32'h0);
    chk({tag, "_err"}, 32'(bus.ld_err), 32'h0);
    chk({tag, "_disp"}, 32'({bus.h_VGA, bus.mi_VGA, bus.s_VGA}), 32'h0);
  endtask

  initial begin
    vec_t e;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));

    //            ld ch ldv        st sp cc tk ak sel  run   ring  act err cd disp
    tbl.push_back(mk(1, 0, 24'h000003, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 0, 0, 0, 0, 4'h1, 4'h0, 0, 0, 1, 24'h000003));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 0, 4'h1, 4'h0, 0, 0, 1, 24'h000003));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 0, 4'h1, 4'h0, 0, 0, 1, 24'h000002));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 0, 4'h0, 4'h1, 0, 0, 1, 24'h000001));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 1, 0, 1, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 0, 4'h0, 4'h1, 1, 0, 0, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 0, 4'h0, 4'h1, 1, 0, 0, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 24'h000000));
    // hour borrow through minutes and seconds
    tbl.push_back(mk(1, 1, 24'h010000, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 1, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 1, 0, 0, 1, 4'h2, 4'h0, 0, 0, 1, 24'h010000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 1, 4'h2, 4'h0, 0, 0, 1, 24'h010000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 1, 4'h2, 4'h0, 0, 0, 1, 24'h005959));
    // rejected loads
    tbl.push_back(mk(1, 2, 24'h240000, 0, 0, 0, 0, 0, 2, 4'h2, 4'h0, 0, 1, 1, 24'h000000));
    tbl.push_back(mk(1, 2, 24'h005A00, 0, 0, 0, 0, 0, 2, 4'h2, 4'h0, 0, 1, 1, 24'h000000));
    tbl.push_back(mk(1, 2, 24'h000010, 0, 0, 0, 0, 0, 2, 4'h2, 4'h0, 0, 0, 1, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 2, 0, 0, 2, 4'h6, 4'h0, 0, 0, 1, 24'h000010));
    tbl.push_back(mk(1, 2, 24'h000005, 0, 0, 0, 0, 0, 2, 4'h6, 4'h0, 0, 1, 1, 24'h000010));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 2, 4'h6, 4'h0, 0, 0, 1, 24'h000010));
    // pause, start+stop collision, tick ignored while paused, load beats start
    tbl.push_back(mk(0, 0, 24'h000000, 0, 1, 1, 0, 0, 2, 4'h4, 4'h0, 0, 0, 1, 24'h000010));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 1, 2, 0, 0, 2, 4'h0, 4'h0, 0, 0, 1, 24'h000010));
    tbl.push_back(mk(0, 0, 24'h000000, 1, 1, 2, 0, 0, 2, 4'h0, 4'h0, 0, 0, 1, 24'h000010));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 2, 4'h0, 4'h0, 0, 0, 1, 24'h000010));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 1, 24'h005959));
    tbl.push_back(mk(1, 2, 24'h000002, 1, 0, 2, 0, 0, 2, 4'h0, 4'h0, 0, 0, 1, 24'h000010));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 2, 4'h0, 4'h0, 0, 0, 1, 24'h000002));
    // simultaneous expiry with held ack
    tbl.push_back(mk(1, 0, 24'h000001, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk(1, 3, 24'h000001, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 0, 0, 0, 0, 4'h1, 4'h0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 3, 0, 0, 0, 4'h9, 4'h0, 0, 0, 0, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 9, 0, 4'h0, 4'h9, 0, 0, 0, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 9, 0, 4'h0, 4'h0, 1, 0, 0, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 24'h000000));
    // ack of an already-ringing channel
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 2, 0, 0, 2, 4'h4, 4'h0, 0, 0, 1, 24'h000002));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 2, 4'h4, 4'h0, 0, 0, 1, 24'h000002));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 2, 4'h0, 4'h4, 0, 0, 1, 24'h000001));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 2, 4'h0, 4'h4, 1, 0, 1, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 4, 2, 4'h0, 4'h0, 1, 0, 1, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 2, 4'h0, 4'h0, 0, 0, 1, 24'h000000));
    // start on zero ignored; max legal value
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1, 24'h000000));
    tbl.push_back(mk(1, 0, 24'h235959, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1, 24'h000000));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1, 24'h235959));
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 0, 0, 0, 0, 4'h1, 4'h0, 0, 0, 1, 24'h235959));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 1, 0, 0, 4'h1, 4'h0, 0, 0, 1, 24'h235959));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 0, 4'h1, 4'h0, 0, 0, 1, 24'h235958));

    // Reset state
    #2 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven run through the scoreboard
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_run", i), 32'(bus.run), 32'(e.e_run));
      chk($sformatf("v%0d_ring", i), 32'(bus.ring), 32'(e.e_ring));
      chk($sformatf("v%0d_act", i), 32'(bus.activring), 32'(e.e_act));
      chk($sformatf("v%0d_lderr", i), 32'(bus.ld_err), 32'(e.e_err));
      if (e.chk_d)
        chk($sformatf("v%0d_disp", i), 32'({bus.h_VGA, bus.mi_VGA, bus.s_VGA}), 32'(e.e_disp));
    end

    // Reset asserted while ch0 is running
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    chk("pre_rst_run", 32'(bus.run), 32'h1);
    rst_n = 1'b0;
    #1 chk_all_zero("midrun_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.tick_1hz = 1'b1;
    @(posedge clk);
    #1 chk_all_zero("post_rst_tick");
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    @(posedge clk);
    #1 chk_all_zero("post_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_timer_bank.md
Name: bcd_timer_bank

Overview:
- Parametrised bank of N_CH independent BCD HH:MM:SS countdown timers with per-channel ring/alarm indication.
- Successor to the single RTC-timer/ring-indicator path. Timers are loaded from the user-input block and counted locally on a 1 Hz tick taken from the RTC seconds change.
- A registered display mux presents one selected channel to the VGA formatter.
- The OR of all ring flags drives the existing ring indicator.

Parameters:
- N_CH, 4, number of timer channels (1..16).
- CH_W, $clog2(N_CH) (min 1), channel-index width; derived, not overridden.
- RING_SEC, 60, number of ticks a ring lasts without acknowledgement (1..255).

Ports:
- CLK  in  1  system clock
- btn_RESET_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  single-cycle pulse, one per second
- ld_en  in  1  load strobe (one cycle)
- ld_ch  in  CH_W  channel to load
- ld_h, ld_m, ld_s  in  8 each  BCD load value, {tens,units}
- start  in  1  start/resume strobe for cmd_ch
- stop  in  1  pause strobe for cmd_ch
- cmd_ch  in  CH_W  channel addressed by start/stop
- apagar_alarma  in  N_CH  per-channel ring acknowledge mask (level, sampled each cycle)
- sel_ch  in  CH_W  channel shown on display outputs
- h_VGA, mi_VGA, s_VGA  out  8 each  BCD value of sel_ch, registered
- run  out  N_CH  channel is counting
- ring  out  N_CH  channel is ringing
- activring  out  1  OR of ring, registered
- ld_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset (async, btn_RESET_n=0):
  - All channels go to IDLE with value 00:00:00 and ring counter 0.
  - All outputs are 0.
  - Reset mid-count or mid-ring aborts silently; no residual ring.
- Per-channel states:
  - IDLE (00 encoding)
  - RUN (01)
  - PAUSE (10)
  - RING (11)
- Load:
  - Accepted only when ld_en=1, ld_ch<N_CH, the target is in IDLE or PAUSE, and the value is valid: each nibble ≤9, h≤23, m≤59, s≤59.
  - On accept: the value is written on the next edge and the state becomes IDLE.
  - Any other ld_en causes a ld_err pulse on the next cycle and no state change.
- Start: IDLE/PAUSE → RUN if value ≠ 00:00:00; ignored otherwise. Start on a RUN or RING channel is ignored.
- Stop: RUN → PAUSE; ignored in other states.
- Same cycle, same channel:
  - stop beats start.
  - A load on a PAUSE channel beats start/stop.
- Tick in RUN: BCD decrement with borrow.
  - Seconds units 0 → 9 with borrow into tens; seconds 00 → 59 with borrow into minutes; minutes likewise; hours decrement.
  - The 00:00:00 wrap can never occur (see expiry).
- Expiry: a tick with value 00:00:01 sets the value to 00:00:00, the state to RING, and the ring counter to RING_SEC, all on that edge. The ring bit rises the same edge.
- RING:
  - Each tick decrements the ring counter.
  - Tick with counter=1 → IDLE and ring clears.
  - apagar_alarma[i]=1 while in RING → IDLE on the next edge.
  - The ack only affects channels already in RING before the edge. A channel expiring on the same edge still rings, so a held ack clears it one cycle later.
- Ticks are ignored in IDLE and PAUSE.
- Channels are fully independent; simultaneous expiries of several channels are all honoured in one cycle.
- Output timing:
  - run and ring are decoded combinationally from state registers (no extra latency).
  - activring is registered (1 cycle after ring).
- Display: h/mi/s_VGA are registered copies of the sel_ch value, 1-cycle latency. sel_ch ≥ N_CH displays 00:00:00.

Decomposition:
- Shared package timer_pkg holds:
  - state encodings IDLE/RUN/PAUSE/RING;
  - BCD limit constants 8'h59 and 8'h23;
  - a function bcd_valid(h,m,s).
- Sub-module bcd_hms_down implements one channel: state register, HH:MM:SS registers, ring counter, decrement/borrow logic. It is instantiated N_CH times via generate.
- The top level holds address decode, ld_err generation, display mux and the activring register.

Test Plan:
- Reset, load ch0=00:00:03, start, 3 ticks → run[0]=1 after start. Value reaches 00:00:00 on the 3rd tick edge, ring[0]=1 that edge, activring=1 one cycle later.
- Load ch1=01:00:00, start, 1 tick → display (sel_ch=1) shows 00:59:59 one cycle after the tick; run[1] stays 1.
- Load ch2=24:00:00, then 00:5A:00, then ch2 load while RUN → ld_err pulses each time and the stored value is unchanged.
- With RING_SEC=3: ch0 expires, no ack, 3 ticks → ring[0] clears on the 3rd tick; state IDLE.
- ch0 and ch3 expire on the same tick with apagar_alarma=4'b1001 held → both ring for exactly one cycle, then clear. Separately, a ringing channel acked → IDLE next edge.
- Start+stop same cycle on a PAUSE channel → stays PAUSE. Assert btn_RESET_n low mid-RUN → all outputs 0 immediately; after release, a tick causes no change.
